word_narrower: RTL and testbench
================================

Name: word_narrower

Overview:
- Store-side counterpart of the load-path sign/zero extenders: narrows an n-bit datapath word to m-bit memory/bus beats.
- Truncate mode emits one m-bit beat with overflow detection and optional saturation.
- Split mode serialises the word into two m-bit beats, low half first.
- Sits between the execute stage and the 16-bit data-memory write port, with valid/ready on both sides.

Parameters:
- m, 16, output beat width.
- n, 32, input word width. Must equal 2*m.
- CW, 8, width of the overflow event counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- I  input  n  word to narrow; sampled on acceptance.
- sw  input  1  signedness: 1 = signed, 0 = unsigned. Sampled with I.
- split  input  1  1 = two-beat split, 0 = single-beat truncate. Sampled with I.
- sat  input  1  1 = saturate on overflow in truncate mode. Sampled with I.
- in_valid  input  1  I, sw, split and sat are valid.
- in_ready  output  1  block can accept a word.
- O  output  m  output beat.
- out_valid  output  1  O is valid.
- out_ready  input  1  consumer accepts O.
- last  output  1  current beat is the final beat of the word.
- ovf  output  1  overflow flag for the current truncate beat.
- ovf_cnt  output  CW  saturating count of overflowed truncate words.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, O=0, last=0, ovf=0, ovf_cnt=0. An in-flight word is discarded and no beat is emitted after reset.
- FSM states IDLE, LO, HI. All outputs are registered; there is no combinational path from in_valid or out_ready to any output.
- in_ready=1 only in IDLE. Throughput is at most one word per 2 cycles (truncate) or per 3 cycles (split).
- IDLE, in_valid=1:
  - Capture I, sw, split and sat.
  - Next cycle: state=LO, out_valid=1.
- IDLE, in_valid=0: hold.
- LO presents the first beat:
  - Truncate: O = I[m-1:0], or the saturated value (see below); last=1; ovf per the rules below.
  - Split: O = I[m-1:0], last=0, ovf=0.
- LO, out_ready=1:
  - Split: go to HI.
  - Truncate: go to IDLE with out_valid=0, and increment ovf_cnt if ovf=1.
- HI presents O = I[n-1:m], last=1, ovf=0. On out_ready=1: go to IDLE, out_valid=0.
- Stall (out_valid=1, out_ready=0): O, last, ovf and state hold unchanged for any number of cycles.
- Overflow detection (truncate mode only):
  - Signed: ovf=1 unless bits I[n-1:m-1] are all equal, i.e. I is the sign extension of I[m-1:0].
  - Unsigned: ovf=1 if I[n-1:m] is nonzero.
  - Split mode never flags overflow.
- Saturation (sat=1, truncate, ovf=1):
  - Signed, I[n-1]=0: O = 0111..1 (0x7FFF for m=16).
  - Signed, I[n-1]=1: O = 1000..0 (0x8000).
  - Unsigned: O = all ones (0xFFFF).
  - With sat=0, O is the plain truncation; ovf is still reported.
- ovf_cnt:
  - Increments by 1 when an overflowed truncate beat is handed off (LO with out_ready=1).
  - Saturates at 2^CW-1 and never wraps.
  - Cleared only by rst.
- Inputs change while busy (not IDLE): ignored; the captured copies are used.
- in_valid and out_ready both high in LO/HI: only the output handshake is taken; the input waits for IDLE.
- Round-trip property: a signed truncate with ovf=0, passed through the 16→32 sign extender, reproduces the original I.

Test Plan:
- Reset mid-word: accept I=0x12345678 split; assert rst while in HI -> immediately out_valid=0, in_ready=1, ovf_cnt=0; no further beats.
- Split, no stall: I=0xDEADBEEF, split=1, out_ready=1 -> beats 0xBEEF (last=0), then 0xDEAD (last=1); in_ready returns 1 after the 2nd beat.
- Signed truncate, no overflow: I=0xFFFF8001, sw=1, split=0 -> O=0x8001, ovf=0, last=1, ovf_cnt unchanged.
- Signed truncate, overflow:
  - I=0x00018000, sw=1, sat=1 -> O=0x7FFF, ovf=1, ovf_cnt +1.
  - Same word with sat=0 -> O=0x8000, ovf=1.
  - I=0x80000000, sw=1, sat=1 -> O=0x8000, ovf=1.
- Unsigned truncate: I=0x0000FFFF, sw=0 -> O=0xFFFF, ovf=0. I=0x00010000, sw=0, sat=1 -> O=0xFFFF, ovf=1.
- Backpressure and counter saturation:
  - Hold out_ready=0 for 5 cycles in LO (split) -> O=low half stable, no state change; changing I and in_valid meanwhile has no effect.
  - Then issue 260 overflowing truncates with CW=8 -> ovf_cnt stops at 255.

Source files
------------

// File: rtl/word_narrower.sv
`default_nettype none
// ============================================================================
// Module   : word_narrower
// Brief    : Narrows an N-bit word to M-bit beats, either as one truncated
//            beat (overflow flag, optional saturation) or two split beats.
// Revision : 1.0 - initial release
// ============================================================================
module word_narrower #(
    parameter int M  = 16,
    parameter int N  = 32,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  I,
    input  logic          sw,
    input  logic          split,
    input  logic          sat,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [M-1:0]  O,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          last,
    output logic          ovf,
    output logic [CW-1:0] ovf_cnt
);

    localparam logic [1:0]    c_st_idle = 2'd0;
    localparam logic [1:0]    c_st_lo   = 2'd1;
    localparam logic [1:0]    c_st_hi   = 2'd2;
    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [M-1:0]  r_hi;
    logic          r_split;

    logic [M-1:0]  w_hi_nxt;
    logic          w_split_nxt;
    logic [M-1:0]  w_o_nxt;
    logic          w_last_nxt;
    logic          w_ovf_nxt;
    logic          w_out_valid_nxt;
    logic          w_in_ready_nxt;
    logic [CW-1:0] w_cnt_nxt;

    logic [M:0]    w_top;
    logic          w_ovf_s;
    logic          w_ovf_u;
    logic          w_ovf_t;
    logic [M-1:0]  w_satv;
    logic [M-1:0]  w_trunc;

    // Truncate result is computed from the live input so the first beat can
    // be registered on the very edge that accepts the word.
    assign w_top   = I[N-1:M-1];
    assign w_ovf_s = ~((&w_top) | ~(|w_top));
    assign w_ovf_u = |I[N-1:M];
    assign w_ovf_t = sw ? w_ovf_s : w_ovf_u;
    assign w_satv  = sw ? (I[N-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}})
                        : {M{1'b1}};
    assign w_trunc = (sat && w_ovf_t) ? w_satv : I[M-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_hi      <= '0;
            r_split   <= 1'b0;
            O         <= '0;
            last      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            ovf_cnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hi      <= w_hi_nxt;
            r_split   <= w_split_nxt;
            O         <= w_o_nxt;
            last      <= w_last_nxt;
            ovf       <= w_ovf_nxt;
            out_valid <= w_out_valid_nxt;
            in_ready  <= w_in_ready_nxt;
            ovf_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (in_valid)  w_state_nxt = c_st_lo;
            c_st_lo:   if (out_ready) w_state_nxt = r_split ? c_st_hi : c_st_idle;
            c_st_hi:   if (out_ready) w_state_nxt = c_st_idle;
            default:                  w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_hi_nxt        = r_hi;
        w_split_nxt     = r_split;
        w_o_nxt         = O;
        w_last_nxt      = last;
        w_ovf_nxt       = ovf;
        w_out_valid_nxt = out_valid;
        w_in_ready_nxt  = in_ready;
        w_cnt_nxt       = ovf_cnt;
        case (r_state)
            c_st_idle: begin
                if (in_valid) begin
                    w_hi_nxt        = I[N-1:M];
                    w_split_nxt     = split;
                    w_o_nxt         = split ? I[M-1:0] : w_trunc;
                    w_last_nxt      = ~split;
                    w_ovf_nxt       = ~split & w_ovf_t;
                    w_out_valid_nxt = 1'b1;
                    w_in_ready_nxt  = 1'b0;
                end
            end
            c_st_lo: begin
                if (out_ready) begin
                    if (r_split) begin
                        w_o_nxt    = r_hi;
                        w_last_nxt = 1'b1;
                        w_ovf_nxt  = 1'b0;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_in_ready_nxt  = 1'b1;
                        w_last_nxt      = 1'b0;
                        w_ovf_nxt       = 1'b0;
                        if (ovf && (ovf_cnt != c_cnt_max))
                            w_cnt_nxt = ovf_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            c_st_hi: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_last_nxt      = 1'b0;
                    w_ovf_nxt       = 1'b0;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_word_narrower.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_narrower
// Brief    : Self-checking bench for word_narrower against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_narrower;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] I = '0;
    logic        sw = 1'b0;
    logic        split = 1'b0;
    logic        sat = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] O;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        last;
    logic        ovf;
    logic [7:0]  ovf_cnt;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    word_narrower #(.M(16), .N(32), .CW(8)) dut (
        .clk(clk), .rst(rst), .I(I), .sw(sw), .split(split), .sat(sat),
        .in_valid(in_valid), .in_ready(in_ready), .O(O), .out_valid(out_valid),
        .out_ready(out_ready), .last(last), .ovf(ovf), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    // Reference: numeric range test on the whole word, beats listed low first.
    function automatic void model(input logic [31:0] w, input logic m_sw, input logic m_split,
                                  input logic m_sat, output logic [31:0] eo,
                                  output logic [1:0] el, output logic [1:0] ev, output int enb);
        int  s;
        bit  of;
        s  = $signed(w);
        eo = '0; el = '0; ev = '0;
        if (m_split) begin
            enb = 2;
            eo  = w;
            el  = 2'b10;
        end else begin
            enb = 1;
            if (m_sw) of = (s > 32767) || (s < -32768);
            else      of = (w > 32'h0000_FFFF);
            eo[15:0] = w[15:0];
            if (of && m_sat) eo[15:0] = m_sw ? ((s > 0) ? 16'h7FFF : 16'h8000) : 16'hFFFF;
            el = 2'b01;
            ev = {1'b0, of};
        end
    endfunction

    // Drives one word through the DUT and records what came out; no checking here.
    task automatic xfer(input logic [31:0] w, input logic x_sw, input logic x_split,
                        input logic x_sat, input int stall_max, input bit chaos,
                        output logic [31:0] oo, output logic [1:0] ol, output logic [1:0] ov,
                        output int nb, output bit to, output bit unstable);
        int          t;
        int          k;
        logic [15:0] held;
        oo = '0; ol = '0; ov = '0; nb = 0; to = 0; unstable = 0;
        t = 0;
        while (in_ready !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        if (in_ready !== 1'b1) begin to = 1; return; end
        I = w; sw = x_sw; split = x_split; sat = x_sat; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (nb < 2) begin
            t = 0;
            while (out_valid !== 1'b1 && t < 8) begin @(negedge clk); t++; end
            if (out_valid !== 1'b1) begin to = 1; return; end
            held = O;
            k = $urandom_range(stall_max, 0);
            repeat (k) begin
                out_ready = 1'b0;
                if (chaos) begin
                    I = $urandom; in_valid = $urandom_range(1, 0);
                    sw = $urandom_range(1, 0); split = $urandom_range(1, 0);
                end
                @(negedge clk);
                if (O !== held || out_valid !== 1'b1) unstable = 1;
            end
            in_valid = 1'b0;
            oo[nb*16 +: 16] = O; ol[nb] = last; ov[nb] = ovf;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            nb++;
            if (ol[nb-1]) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (O !== 16'h0) begin bad++; $display("FAIL rst_O got=%h exp=0000", O); end
        total++; if (last !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL rst_last_ovf got=%b%b exp=00", last, ovf); end
        total++; if (ovf_cnt !== 8'd0) begin bad++; $display("FAIL rst_ovf_cnt got=%0d exp=0", ovf_cnt); end
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_split;
        logic [31:0] oo;
        logic [1:0]  ol, ov;
        int          nb;
        bit          to, un;
        xfer(32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 0, 0, oo, ol, ov, nb, to, un);
        total++; if (to || nb !== 2) begin bad++; $display("FAIL split_beats got=%0d to=%0d exp=2", nb, to); end
        total++; if (oo[15:0] !== 16'hBEEF || ol[0] !== 1'b0) begin bad++; $display("FAIL split_lo got=%h/%b exp=beef/0", oo[15:0], ol[0]); end
        total++; if (oo[31:16] !== 16'hDEAD || ol[1] !== 1'b1) begin bad++; $display("FAIL split_hi got=%h/%b exp=dead/1", oo[31:16], ol[1]); end
        total++; if (ov !== 2'b00) begin bad++; $display("FAIL split_ovf got=%b exp=00", ov); end
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL split_idle got=%b%b exp=10", in_ready, out_valid); end
    endtask

    task automatic test_truncate;
        logic [31:0] vw [8] = '{32'hFFFF8001, 32'h00018000, 32'h00018000, 32'h80000000,
                                32'h0000FFFF, 32'h00010000, 32'h00007FFF, 32'h00008000};
        logic        vs [8] = '{1, 1, 1, 1, 0, 0, 1, 1};
        logic        vt [8] = '{0, 1, 0, 1, 0, 1, 1, 1};
        logic [15:0] vo [8] = '{16'h8001, 16'h7FFF, 16'h8000, 16'h8000,
                                16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFF};
        logic        vf [8] = '{0, 1, 1, 1, 0, 1, 0, 1};
        logic [31:0] oo;
        logic [1:0]  ol, ov;
        int          nb;
        bit          to, un;
        for (int i = 0; i < 8; i++) begin
            xfer(vw[i], vs[i], 1'b0, vt[i], 0, 0, oo, ol, ov, nb, to, un);
            if (vf[i] && exp_cnt < 255) exp_cnt++;
            total++; if (to || nb !== 1) begin bad++; $display("FAIL trunc%0d_beats got=%0d to=%0d exp=1", i, nb, to); end
            total++; if (oo[15:0] !== vo[i]) begin bad++; $display("FAIL trunc%0d_O got=%h exp=%h", i, oo[15:0], vo[i]); end
            total++; if (ov[0] !== vf[i] || ol[0] !== 1'b1) begin bad++; $display("FAIL trunc%0d_flags ovf=%b last=%b exp=%b/1", i, ov[0], ol[0], vf[i]); end
            total++; if (ovf_cnt !== exp_cnt[7:0]) begin bad++; $display("FAIL trunc%0d_cnt got=%0d exp=%0d", i, ovf_cnt, exp_cnt); end
        end
    endtask

    task automatic test_stall;
        @(negedge clk);
        I = 32'hCAFE1234; sw = 1'b0; split = 1'b1; sat = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            I = $urandom; in_valid = 1'b1; split = 1'b0; sw = 1'b1; sat = 1'b1;
            out_ready = 1'b0;
            total++;
            if (O !== 16'h1234 || out_valid !== 1'b1 || last !== 1'b0 || in_ready !== 1'b0) begin
                bad++; $display("FAIL stall%0d got O=%h v=%b l=%b r=%b exp 1234/1/0/0", i, O, out_valid, last, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++; if (O !== 16'h1234) begin bad++; $display("FAIL stall_lo got=%h exp=1234", O); end
        @(negedge clk);
        total++; if (O !== 16'hCAFE || last !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hi got=%h/%b/%b exp=cafe/1/1", O, last, out_valid); end
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL stall_idle got=%b%b exp=01", out_valid, in_ready); end
    endtask

    task automatic test_random;
        logic [31:0] w, r, oo, eo;
        logic [1:0]  ol, ov, el, ev;
        logic        rs, rp, rt;
        int          nb, enb;
        bit          to, un;
        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            case ($urandom_range(3, 0))
                0:       w = r;
                1:       w = {{16{r[15]}}, r[15:0]};
                2:       w = {16'h0000, r[15:0]};
                default: w = {{15{r[20]}}, r[16:0]};
            endcase
            rs = $urandom_range(1, 0); rp = $urandom_range(1, 0); rt = $urandom_range(1, 0);
            model(w, rs, rp, rt, eo, el, ev, enb);
            xfer(w, rs, rp, rt, 3, 1, oo, ol, ov, nb, to, un);
            if (ev[0] && exp_cnt < 255) exp_cnt++;
            total++;
            if (to || un || nb !== enb || oo !== eo || ol !== el || ov !== ev) begin
                bad++;
                $display("FAIL rand%0d w=%h got O=%h l=%b v=%b n=%0d to=%0d un=%0d exp O=%h l=%b v=%b n=%0d",
                         i, w, oo, ol, ov, nb, to, un, eo, el, ev, enb);
            end
            total++; if (ovf_cnt !== exp_cnt[7:0]) begin bad++; $display("FAIL rand%0d_cnt got=%0d exp=%0d", i, ovf_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid_word;
        @(negedge clk);
        I = 32'h12345678; sw = 1'b0; split = 1'b1; sat = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (O !== 16'h1234 || out_valid !== 1'b1) begin bad++; $display("FAIL rmid_hi got=%h/%b exp=1234/1", O, out_valid); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        total++; if (ovf_cnt !== 8'd0) begin bad++; $display("FAIL rmid_ovf_cnt got=%0d exp=0", ovf_cnt); end
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_beat%0d got=%b exp=0", i, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_cnt_sat;
        logic [31:0] w, oo;
        logic [1:0]  ol, ov;
        int          nb;
        bit          to, un;
        for (int i = 0; i < 260; i++) begin
            w = {2'b01, 30'($urandom)};
            xfer(w, 1'($urandom_range(1, 0)), 1'b0, 1'($urandom_range(1, 0)), 0, 0, oo, ol, ov, nb, to, un);
            if (exp_cnt < 255) exp_cnt++;
            total++;
            if (to || ov[0] !== 1'b1 || ovf_cnt !== exp_cnt[7:0]) begin
                bad++; $display("FAIL cnt%0d got cnt=%0d ovf=%b to=%0d exp cnt=%0d ovf=1", i, ovf_cnt, ov[0], to, exp_cnt);
            end
        end
        total++; if (ovf_cnt !== 8'd255) begin bad++; $display("FAIL cnt_final got=%0d exp=255", ovf_cnt); end
    endtask

    initial begin
        test_reset;
        test_split;
        test_truncate;
        test_stall;
        test_random;
        test_reset_mid_word;
        test_cnt_sat;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
